rn_axis_pkt_player: RTL
=======================

Name: rn_axis_pkt_player

Overview:
Parametrised AXI-Stream packet replayer and successor to the simulation stimulus driver. Beats are loaded into an internal beat buffer through a valid/ready load port, then replayed as whole packets on a fully AXIS-compliant master port, with:
- tvalid held until accepted;
- tdest channel selection;
- programmable inter-packet gap;
- repeat/wrap up to a packet count;
- sticky error flags.
It sits between bench stimulus sources and the RecoNIC packet input and is synthesizable for on-board traffic generation.

Parameters:
DATA_WIDTH, 512, AXIS data width in bits
KEEP_WIDTH, DATA_WIDTH/8, tkeep width
USER_SIZE_WIDTH, 16, packet byte length carried in tuser_size
NUM_CH, 4, number of destination channels; DEST_W = max(1,$clog2(NUM_CH))
DEPTH, 1024, beat buffer depth (power of 2); PTR_W = $clog2(DEPTH)
GAP_WIDTH, 16, width of the inter-packet gap register
START_DELAY, 100, idle cycles between start and first beat

Ports:
axis_clk  in  1  clock
axis_rst  in  1  synchronous active-high reset
clear  in  1  empty the buffer; honoured in IDLE/DONE only
s_load_tvalid  in  1  load beat valid
s_load_tready  out  1  load beat accepted
s_load_tdata  in  DATA_WIDTH  beat data
s_load_tkeep  in  KEEP_WIDTH  beat keep
s_load_tlast  in  1  last beat of packet
s_load_tdest  in  DEST_W  destination channel
s_load_tuser_size  in  USER_SIZE_WIDTH  packet byte length
start  in  1  begin replay; pulse
num_pkts  in  32  packets to send; sampled on start
gap_cycles  in  GAP_WIDTH  idle cycles after each tlast; sampled on start
m_axis_tdata  out  DATA_WIDTH  stream data
m_axis_tkeep  out  KEEP_WIDTH  stream keep
m_axis_tlast  out  1  stream last
m_axis_tdest  out  DEST_W  stream destination
m_axis_tuser_size  out  USER_SIZE_WIDTH  packet length
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
busy  out  1  state in DELAY/SEND/GAP
done  out  1  replay finished; level, held until next start
pkt_cnt  out  32  packets sent since start
beat_cnt  out  32  beats sent since start
load_overflow  out  1  sticky: load attempted while buffer full
fmt_err  out  1  sticky: buffer end reached without tlast
empty_err  out  1  sticky: start with empty buffer and num_pkts>0

Behaviour:
- Reset: state IDLE; all outputs 0; wr_ptr/rd_ptr/counters 0; buffer contents undefined. Reset mid-replay aborts; tvalid is 0 from the first cycle after the reset edge.
- States:
  - IDLE/DONE -> DELAY on start, and it clears pkt_cnt, beat_cnt and rd_ptr.
  - In IDLE/DONE, num_pkts==0 goes straight to DONE.
  - In IDLE/DONE, an empty buffer with num_pkts>0 goes to DONE and sets empty_err.
  - DELAY counts START_DELAY cycles -> SEND.
  - SEND: after a tlast handshake, -> DONE when pkt_cnt+1==num_pkts; else -> GAP if gap_cycles>0; else stay in SEND.
  - GAP counts gap_cycles idle cycles (tvalid=0) -> SEND.
  - start is ignored while busy.
- Load:
  - s_load_tready = (state IDLE or DONE) && count<DEPTH.
  - A beat writes on valid&&ready; wr_ptr increments.
  - s_load_tvalid && count==DEPTH in IDLE/DONE sets load_overflow.
  - clear resets wr_ptr to 0, clears the sticky flags and takes priority over a same-cycle load.
  - clear and start in the same cycle: clear wins, then empty_err logic applies to the now-empty buffer.
- Replay:
  - Buffer read is 1-cycle latency with prefetch; the first tvalid rises ≤2 cycles after entering SEND.
  - Sustained throughput is 1 beat/cycle under continuous tready.
  - Once tvalid=1, all m_axis_* outputs are stable until tvalid&&tready.
  - beat_cnt increments per handshake; pkt_cnt increments per tlast handshake.
- Wrap: when rd_ptr reaches wr_ptr and more packets remain, rd_ptr returns to 0 (stream repeats). If the beat at wr_ptr-1 lacks tlast, it is output with tlast forced to 1 and fmt_err is set.
- Counters saturate at 32'hFFFF_FFFF.

Optional Feature:
RN_PLAYER_FILLER_SKIP_EN:
- Defined: beats with tdata[63:0]==64'hDDDD_DDDD_DDDD_DDDD are never presented on m_axis and do not count in beat_cnt. At most one bubble cycle per skipped beat. A skipped beat carrying tlast still ends the packet: pkt_cnt increments and GAP/DONE transitions occur.
- Undefined: filler beats are sent as ordinary data.

Decomposition:
- rn_tb_pkg gains:
  - rn_player_state_e (IDLE, DELAY, SEND, GAP, DONE);
  - RN_FILLER_PATTERN constant;
  - parametrised beat struct (tdata, tkeep, tlast, tdest, tuser_size) via a packed-width localparam helper.
- Sub-module: rn_axis_pkt_player_mem, a simple dual-port DEPTH-entry beat RAM with 1-cycle registered read.

Test Plan:
- Load 2 packets (3 beats, 1 beat; tdest 1,2), num_pkts=2, gap=0, tready=1 -> 4 beats back-to-back, tlast on beats 3 and 4, tdest 1,1,1,2, done=1, pkt_cnt=2, beat_cnt=4.
- Same load, num_pkts=5, gap=3 -> wrap occurs; exactly 3 idle cycles after each tlast; pkt_cnt=5; final packet is packet 1.
- Random tready (50%) on a 3-beat packet -> no data change while tvalid&&!tready; beat order intact; beat_cnt=3.
- Load DEPTH+1 beats -> s_load_tready=0 at DEPTH; load_overflow=1; clear -> flag cleared, tready=1.
- Start with empty buffer, num_pkts=1 -> done=1 and empty_err=1 within 2 cycles; no tvalid. Then load a single beat without tlast, num_pkts=1 -> that beat is output with tlast=1 and fmt_err=1.
- Assert axis_rst during SEND -> tvalid=0 next cycle, state IDLE. With RN_PLAYER_FILLER_SKIP_EN, a filler middle beat is absent from the output and beat_cnt=2 for a 3-beat packet.

Source files
------------

// File: rtl/rn_tb_pkg.sv
// Shared types and constants for the AXI-Stream packet player: FSM state
// encoding, the filler pattern and the packed beat width helper.
package rn_tb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    SEND  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } rn_player_state_e;

  localparam logic [63:0] RN_FILLER_PATTERN = 64'hDDDD_DDDD_DDDD_DDDD;

  // Width of a packed beat {tdata, tkeep, tlast, tdest, tuser_size}
  function automatic int rn_beat_w(input int data_w, input int keep_w,
                                   input int dest_w, input int size_w);
    return data_w + keep_w + 1 + dest_w + size_w;
  endfunction

endpackage

// File: rtl/rn_axis_pkt_player_mem.sv
// Simple dual-port beat RAM: one write port, one read port with a
// registered (1-cycle) read that holds its value while re is low.
module rn_axis_pkt_player_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/rn_axis_pkt_player.sv
// AXI-Stream packet player: loads beats into a buffer, then replays whole
// packets with start delay, inter-packet gap and wrap. Optional macro
// RN_PLAYER_FILLER_SKIP_EN drops filler beats from the output stream.
module rn_axis_pkt_player
  import rn_tb_pkg::*;
#(
  parameter int DATA_WIDTH      = 512,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int USER_SIZE_WIDTH = 16,
  parameter int NUM_CH          = 4,
  parameter int DEST_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int DEPTH           = 1024,
  parameter int GAP_WIDTH       = 16,
  parameter int START_DELAY     = 100
) (
  input  logic                       axis_clk,
  input  logic                       axis_rst,
  input  logic                       clear,
  input  logic                       s_load_tvalid,
  output logic                       s_load_tready,
  input  logic [DATA_WIDTH-1:0]      s_load_tdata,
  input  logic [KEEP_WIDTH-1:0]      s_load_tkeep,
  input  logic                       s_load_tlast,
  input  logic [DEST_W-1:0]          s_load_tdest,
  input  logic [USER_SIZE_WIDTH-1:0] s_load_tuser_size,
  input  logic                       start,
  input  logic [31:0]                num_pkts,
  input  logic [GAP_WIDTH-1:0]       gap_cycles,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]      m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic [DEST_W-1:0]          m_axis_tdest,
  output logic [USER_SIZE_WIDTH-1:0] m_axis_tuser_size,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                pkt_cnt,
  output logic [31:0]                beat_cnt,
  output logic                       load_overflow,
  output logic                       fmt_err,
  output logic                       empty_err
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int BEAT_W = rn_beat_w(DATA_WIDTH, KEEP_WIDTH, DEST_W, USER_SIZE_WIDTH);
  localparam logic [PTR_W:0]       PTR_ONE  = 1;
  localparam logic [GAP_WIDTH-1:0] GAP_ONE  = 1;
  localparam logic [31:0]          DLY_INIT = (START_DELAY > 0) ? 32'(START_DELAY - 1) : 32'd0;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]      tdata;
    logic [KEEP_WIDTH-1:0]      tkeep;
    logic                       tlast;
    logic [DEST_W-1:0]          tdest;
    logic [USER_SIZE_WIDTH-1:0] tuser_size;
  } beat_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  rn_player_state_e r_state, w_state_nxt;

  logic [PTR_W:0]       r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr, r_p1_addr;
  logic                 r_p1_vld;
  beat_t                r_out;
  logic                 r_out_vld, r_out_skip, r_out_fmt;
  logic [31:0]          r_num_pkts, r_pkt_cnt, r_beat_cnt, r_dly_cnt;
  logic [GAP_WIDTH-1:0] r_gap_cfg, r_gap_cnt;
  logic                 r_load_ovf, r_fmt_err, r_empty_err;

  logic                 w_idle, w_send, w_busy, w_full, w_load_fire, w_start_ok, w_empty_now;
  logic                 w_fire, w_fire_last, w_last_pkt, w_out_free, w_rd_en, w_xfer;
  logic                 w_p1_end, w_is_filler;
  logic [PTR_W:0]       w_rd_inc;
  logic [PTR_W-1:0]     w_rd_nxt;
  logic [BEAT_W-1:0]    w_rdata_raw;
  beat_t                w_rdata, w_wbeat, w_beat;

  assign w_full      = r_wr_ptr[PTR_W];
  assign w_load_fire = s_load_tvalid && s_load_tready && !clear;
  assign w_start_ok  = start && w_idle;
  assign w_empty_now = clear || (r_wr_ptr == '0);
  assign w_fire      = w_send && r_out_vld && (r_out_skip || m_axis_tready);
  assign w_fire_last = w_fire && r_out.tlast;
  assign w_last_pkt  = ({1'b0, r_pkt_cnt} + 33'd1) == {1'b0, r_num_pkts};
  assign w_out_free  = !r_out_vld || w_fire;
  assign w_rd_en     = w_busy && (!r_p1_vld || w_out_free);
  assign w_xfer      = w_busy && r_p1_vld && w_out_free;
  assign w_p1_end    = ({1'b0, r_p1_addr} + PTR_ONE) == r_wr_ptr;
  assign w_rd_inc    = {1'b0, r_rd_ptr} + PTR_ONE;
  assign w_rd_nxt    = (w_rd_inc == r_wr_ptr) ? '0 : w_rd_inc[PTR_W-1:0];
  assign w_rdata     = beat_t'(w_rdata_raw);

`ifdef RN_PLAYER_FILLER_SKIP_EN
  assign w_is_filler = (w_rdata.tdata[63:0] == RN_FILLER_PATTERN);
`else
  assign w_is_filler = 1'b0;
`endif

  always_comb begin
    w_wbeat = '{tdata: s_load_tdata, tkeep: s_load_tkeep, tlast: s_load_tlast,
                tdest: s_load_tdest, tuser_size: s_load_tuser_size};
    // The buffer's final beat always closes a packet so the replay can wrap
    w_beat       = w_rdata;
    w_beat.tlast = w_rdata.tlast | w_p1_end;
  end

  rn_axis_pkt_player_mem #(
    .WIDTH (BEAT_W),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (axis_clk),
    .we    (w_load_fire),
    .waddr (r_wr_ptr[PTR_W-1:0]),
    .wdata (w_wbeat),
    .re    (w_rd_en),
    .raddr (r_rd_ptr),
    .rdata (w_rdata_raw)
  );

  always_ff @(posedge axis_clk) begin
    if (axis_rst) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          if (num_pkts == 32'd0 || w_empty_now) w_state_nxt = DONE;
          else                                   w_state_nxt = DELAY;
        end
      end
      DELAY: if (r_dly_cnt == 32'd0) w_state_nxt = SEND;
      SEND: begin
        if (w_fire_last) begin
          if (w_last_pkt)                w_state_nxt = DONE;
          else if (r_gap_cfg != '0)      w_state_nxt = GAP;
        end
      end
      GAP: if (r_gap_cnt == '0) w_state_nxt = SEND;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_idle        = (r_state == IDLE) || (r_state == DONE);
    w_send        = (r_state == SEND);
    w_busy        = (r_state == DELAY) || (r_state == SEND) || (r_state == GAP);
    s_load_tready = w_idle && !w_full;
    busy          = w_busy;
    done          = (r_state == DONE);
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_p1_addr   <= '0;
      r_p1_vld    <= 1'b0;
      r_out       <= '0;
      r_out_vld   <= 1'b0;
      r_out_skip  <= 1'b0;
      r_out_fmt   <= 1'b0;
      r_num_pkts  <= '0;
      r_pkt_cnt   <= '0;
      r_beat_cnt  <= '0;
      r_dly_cnt   <= '0;
      r_gap_cfg   <= '0;
      r_gap_cnt   <= '0;
      r_load_ovf  <= 1'b0;
      r_fmt_err   <= 1'b0;
      r_empty_err <= 1'b0;
    end else begin
      if (w_load_fire) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_idle && clear) begin
        r_wr_ptr   <= '0;
        r_load_ovf <= 1'b0;
        r_fmt_err  <= 1'b0;
        r_empty_err <= 1'b0;
      end
      if (w_idle && !clear && s_load_tvalid && w_full) r_load_ovf <= 1'b1;
      if (w_start_ok && num_pkts != 32'd0 && w_empty_now) r_empty_err <= 1'b1;
      if (w_fire && r_out_fmt) r_fmt_err <= 1'b1;

      if (w_start_ok) begin
        r_pkt_cnt  <= '0;
        r_beat_cnt <= '0;
        r_rd_ptr   <= '0;
        r_p1_vld   <= 1'b0;
        r_out_vld  <= 1'b0;
        r_num_pkts <= num_pkts;
        r_gap_cfg  <= gap_cycles;
        r_dly_cnt  <= DLY_INIT;
      end else begin
        if (r_state == DELAY && r_dly_cnt != 32'd0) r_dly_cnt <= r_dly_cnt - 32'd1;
        if (r_state == GAP && r_gap_cnt != '0)      r_gap_cnt <= r_gap_cnt - GAP_ONE;
        if (w_fire_last) begin
          r_gap_cnt <= r_gap_cfg - GAP_ONE;
          r_pkt_cnt <= sat_inc(r_pkt_cnt);
        end
        if (w_fire && !r_out_skip) r_beat_cnt <= sat_inc(r_beat_cnt);

        // Prefetch runs through DELAY and GAP so the next beat is ready on SEND entry
        if (w_rd_en) begin
          r_rd_ptr  <= w_rd_nxt;
          r_p1_addr <= r_rd_ptr;
          r_p1_vld  <= 1'b1;
        end else if (w_xfer) begin
          r_p1_vld  <= 1'b0;
        end

        if (w_xfer) begin
          r_out      <= w_beat;
          r_out_vld  <= 1'b1;
          r_out_skip <= w_is_filler;
          r_out_fmt  <= w_p1_end && !w_rdata.tlast;
        end else if (w_fire) begin
          r_out_vld  <= 1'b0;
        end

        if (w_state_nxt == DONE && r_state != DONE) begin
          r_p1_vld  <= 1'b0;
          r_out_vld <= 1'b0;
        end
      end
    end
  end

  assign m_axis_tvalid     = w_send && r_out_vld && !r_out_skip;
  assign m_axis_tdata      = r_out.tdata;
  assign m_axis_tkeep      = r_out.tkeep;
  assign m_axis_tlast      = r_out.tlast;
  assign m_axis_tdest      = r_out.tdest;
  assign m_axis_tuser_size = r_out.tuser_size;
  assign pkt_cnt           = r_pkt_cnt;
  assign beat_cnt          = r_beat_cnt;
  assign load_overflow     = r_load_ovf;
  assign fmt_err           = r_fmt_err;
  assign empty_err         = r_empty_err;

endmodule
